// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the CPU-bus memory responder and its program loader.
package mem_responder_pkg;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    localparam logic RDWR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        DONE    = 2'd3
    } ld_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus plus byte-serial loader signals; master is the CPU/host side, slave the responder.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic          en;
    logic          rdwr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ld_start;
    logic          ld_valid;
    logic [BW-1:0] ld_byte;
    logic          ld_last;
    logic          ld_ready;
    logic          cpu_hold;
    logic          ld_err;
    logic [AW:0]   ld_count;

    modport master (
        output en, rdwr, addr, wdata, ld_start, ld_valid, ld_byte, ld_last,
        input  rdata, ld_ready, cpu_hold, ld_err, ld_count
    );

    modport slave (
        input  en, rdwr, addr, wdata, ld_start, ld_valid, ld_byte, ld_last,
        output rdata, ld_ready, cpu_hold, ld_err, ld_count
    );

endinterface

// File: rtl/sp_ram_sync.sv
// Single-port word RAM with registered read; accesses at or beyond DEPTH read 0 and never write.
module sp_ram_sync #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rstT,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic          in_range_c;
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Read data only moves on a read strobe; writes leave it untouched.
    always_comb begin
        in_range_c = {1'b0, addr} < DEPTH_W;
        rdata_d    = rdata_q;
        if (en && !we) begin
            rdata_d = in_range_c ? mem[addr[IW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (en && we && in_range_c) begin
            mem[addr[IW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rstT) begin
        if (rstT) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: serves CPU bus accesses and runs the byte-serial program loader,
// holding the CPU in reset while the loader owns the RAM port.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rstT,
    mem_responder_if.slave  bus
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    ld_state_e     state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [BW-1:0] hi_q, hi_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic          hold_q, hold_d;
    logic          ld_wr_c;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    // Loader FSM; the word counter doubles as the RAM write pointer and saturates at DEPTH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        err_d   = err_q;
        ld_wr_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    state_d = LOAD_HI;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD_HI: begin
                if (bus.ld_valid) begin
                    if (bus.ld_last) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        hi_d    = bus.ld_byte;
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (bus.ld_valid) begin
                    if (cnt_q < DEPTH_W) begin
                        ld_wr_c = 1'b1;
                        cnt_d   = cnt_q + (AW+1)'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = bus.ld_last ? DONE : LOAD_HI;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LOAD_HI) || (state_d == LOAD_LO);
        hold_d  = (state_d != IDLE);
    end

    // The CPU is masked whenever it is held, so the loader has the port to itself.
    always_comb begin
        if (hold_q) begin
            ram_en    = ld_wr_c;
            ram_we    = 1'b1;
            ram_addr  = cnt_q[AW-1:0];
            ram_wdata = {hi_q, bus.ld_byte};
        end else begin
            ram_en    = bus.en;
            ram_we    = (bus.rdwr == RDWR_WRITE);
            ram_addr  = bus.addr;
            ram_wdata = bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rstT) begin
        if (rstT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
        end
    end

    sp_ram_sync #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .rstT  (rstT),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (bus.rdata)
    );

    assign bus.ld_ready = ready_q;
    assign bus.cpu_hold = hold_q;
    assign bus.ld_err   = err_q;
    assign bus.ld_count = cnt_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit accumulator CPU bus. It serves the CPU's instruction fetches, operand reads and stores from an internal single-port word RAM.
- Contains a byte-serial program loader. The loader fills the RAM while holding the CPU in reset, then releases it.
- Sits between the CPU bus pins (addr, dataout, datain, en, rdwr) and the top-level loader/host interface.

Parameters:
- DEPTH, 1024, number of 16-bit words implemented; must be ≤ 4096.
- AW, 12, CPU address width.
- DW, 16, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- rstT  input  1  reset, asynchronous, active-high.
- en  input  1  CPU bus access strobe, one cycle per access.
- rdwr  input  1  CPU access type: 1 = write, 0 = read.
- addr  input  AW  CPU word address.
- wdata  input  DW  CPU write data (CPU dataout).
- rdata  output  DW  read data to the CPU (CPU datain).
- ld_start  input  1  one-cycle pulse that begins a program load.
- ld_valid  input  1  a loader byte is presented.
- ld_byte  input  8  loader byte; high byte first, then low byte.
- ld_last  input  1  qualifies the current byte as the final byte.
- ld_ready  output  1  responder accepts a loader byte this cycle.
- cpu_hold  output  1  drives CPU reset while a load is in progress.
- ld_err  output  1  sticky error: ld_last arrived on a high byte.
- ld_count  output  AW+1  number of words written by the last or current load.

Behaviour:
- Reset values:
  - rdata = 0, cpu_hold = 0, ld_ready = 0, ld_err = 0, ld_count = 0.
  - FSM in IDLE; RAM contents are not reset.
- CPU read:
  - If en=1 and rdwr=0 in cycle N, rdata <= mem[addr] at the edge ending cycle N.
  - rdata is stable throughout cycle N+1, when the CPU samples it.
  - rdata holds its value on every non-read cycle.
- CPU write:
  - If en=1 and rdwr=1 in cycle N, mem[addr] <= wdata at the edge ending cycle N.
  - rdata is unchanged by a write.
- Out of range (addr ≥ DEPTH):
  - A read returns 0.
  - A write is dropped.
- While cpu_hold=1, CPU en is ignored: no RAM access and no rdata update.
- FSM states are IDLE, LOAD_HI, LOAD_LO and DONE.
- IDLE:
  - ld_ready = 0, cpu_hold = 0.
  - On ld_start: go to LOAD_HI, clear the write pointer and ld_count, clear ld_err, set cpu_hold = 1.
- LOAD_HI:
  - ld_ready = 1.
  - ld_valid with ld_last=0: latch ld_byte into the high holding register, go to LOAD_LO.
  - ld_valid with ld_last=1: set ld_err, write nothing, go to DONE.
- LOAD_LO:
  - ld_ready = 1.
  - ld_valid: mem[ptr] <= {hi, ld_byte} if ptr < DEPTH; ptr++; ld_count++.
  - Next state is DONE if ld_last=1, otherwise LOAD_HI.
- Pointer wrap: if ptr reaches DEPTH without ld_last, further words are dropped, ld_count saturates at DEPTH and ld_err is set.
- DONE:
  - One cycle with ld_ready = 0 and cpu_hold still 1, then IDLE.
  - cpu_hold therefore falls at the edge leaving DONE.
- ld_start while not in IDLE is ignored.
- rstT mid-load:
  - FSM returns to IDLE and cpu_hold drops immediately (asynchronously).
  - Words already written remain in RAM; the partial high byte is lost.
- Simultaneous loader write and CPU access cannot occur, because the CPU is masked by cpu_hold.

Decomposition:
- Shared package holds:
  - the loader state enum {IDLE, LOAD_HI, LOAD_LO, DONE};
  - the constants AW=12 and DW=16;
  - the RDWR_WRITE=1 encoding.
- Single sub-module sp_ram_sync: single-port, write-first-irrelevant, registered-read RAM of DEPTH×DW with address-range guard.
- The top arbitrates the sp_ram_sync port between the loader FSM and the CPU.

Test Plan:
- Reset, then CPU write 16'hBEEF to 12'h010, then read 12'h010 → rdata = 16'hBEEF in the cycle after the read strobe; rdata unchanged during the write cycle.
- ld_start, then bytes 0x20,0x05 / 0x70,0x01 with ld_last on 0x01 → mem[0] = 16'h2005, mem[1] = 16'h7001, ld_count = 2, ld_err = 0; cpu_hold high from the cycle after ld_start until after DONE.
- Load with ld_last on the third byte (a high byte) → ld_err = 1, only mem[0] written, ld_count = 1, FSM returns to IDLE.
- CPU read of 12'h7FF (beyond DEPTH=1024) → rdata = 0; write 16'h1234 to 12'h7FF followed by a read of 12'h3FF → mem[1023] not corrupted.
- Assert rstT after the high byte of word 3 of a load → cpu_hold = 0 immediately, words 0–2 retained, a new ld_start restarts at ptr 0.
- CPU en pulses during cpu_hold=1 → no RAM change and no rdata change.
